// File: rtl/puf_crp_sequencer.sv
// rtl/puf_crp_sequencer.sv - arbiter PUF challenge/response collection engine (optional LFSR challenge mode: PUF_CRP_LFSR_EN)
module puf_crp_sequencer #(
   parameter int EVALS  = 5,   // evaluations per challenge, odd, 1..15
   parameter int SETTLE = 4    // cycles per pulse phase, minimum 3
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   input  logic [7:0] seed,
   input  logic [7:0] n_words,
   output logic [7:0] challenge,
   output logic       pulse,
   input  logic       response,
   output logic       word_valid,
   input  logic       word_ready,
   output logic [7:0] word,
   output logic [7:0] mask,
   output logic       busy,
   output logic       done
);
   typedef enum logic [2:0] {
      S_IDLE, S_SETUP, S_FIRE, S_SAMPLE, S_VOTE, S_OUT, S_FINISH
   } state_t;

   localparam logic [7:0] PH_LAST = 8'(SETTLE - 1);
   localparam logic [3:0] EV_ALL  = 4'(EVALS);
   localparam logic [3:0] EV_HALF = 4'(EVALS / 2);

   state_t     state_q, state_d;
   logic [7:0] chal_q, chal_d;
   logic [7:0] phase_q, phase_d;
   logic [7:0] words_q, words_d;
   logic [7:0] word_q, word_d;
   logic [7:0] mask_q, mask_d;
   logic [3:0] votes_q, votes_d;
   logic [3:0] evals_q, evals_d;
   logic [2:0] bit_q, bit_d;
   logic       valid_q, valid_d;
   logic       busy_q, busy_d;
   logic       pulse_q, done_q;
   logic       sync1_q, sync2_q;
   logic [7:0] seed_eff, chal_next;
   logic       vote_bit, vote_unstable;

`ifdef PUF_CRP_LFSR_EN
   // An all-zero LFSR state would lock up, so a zero seed is forced to 01h.
   assign seed_eff  = (seed == 8'h00) ? 8'h01 : seed;
   assign chal_next = {chal_q[6:0], chal_q[7] ^ chal_q[5] ^ chal_q[4] ^ chal_q[3]};
`else
   assign seed_eff  = seed;
   assign chal_next = chal_q + 8'd1;
`endif

   assign vote_bit      = votes_q > EV_HALF;
   assign vote_unstable = (votes_q != 4'd0) && (votes_q != EV_ALL);

   // Bring the asynchronous arbiter output into the clk domain.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
      end else begin
         sync1_q <= response;
         sync2_q <= sync1_q;
      end
   end

   // State and datapath registers; pulse and done are registered from the next state.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         chal_q  <= 8'h00;
         phase_q <= 8'h00;
         words_q <= 8'h00;
         word_q  <= 8'h00;
         mask_q  <= 8'h00;
         votes_q <= 4'd0;
         evals_q <= 4'd0;
         bit_q   <= 3'd0;
         valid_q <= 1'b0;
         busy_q  <= 1'b0;
         pulse_q <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         chal_q  <= chal_d;
         phase_q <= phase_d;
         words_q <= words_d;
         word_q  <= word_d;
         mask_q  <= mask_d;
         votes_q <= votes_d;
         evals_q <= evals_d;
         bit_q   <= bit_d;
         valid_q <= valid_d;
         busy_q  <= busy_d;
         pulse_q <= (state_d == S_FIRE);
         done_q  <= (state_d == S_FINISH);
      end
   end

   // Sequencing: settle/fire phases, vote accumulation, word packing and handoff.
   always_comb begin
      state_d = state_q;
      chal_d  = chal_q;
      phase_d = 8'h00;
      words_d = words_q;
      word_d  = word_q;
      mask_d  = mask_q;
      votes_d = votes_q;
      evals_d = evals_q;
      bit_d   = bit_q;
      valid_d = 1'b0;
      busy_d  = busy_q;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               chal_d  = seed_eff;
               words_d = n_words;
               votes_d = 4'd0;
               evals_d = 4'd0;
               bit_d   = 3'd0;
               word_d  = 8'h00;
               mask_d  = 8'h00;
               busy_d  = 1'b1;
               state_d = (n_words == 8'h00) ? S_FINISH : S_SETUP;
            end
         end
         S_SETUP: begin
            if (phase_q == PH_LAST) state_d = S_FIRE;
            else                    phase_d = phase_q + 8'd1;
         end
         S_FIRE: begin
            if (phase_q == PH_LAST) state_d = S_SAMPLE;
            else                    phase_d = phase_q + 8'd1;
         end
         S_SAMPLE: begin
            votes_d = votes_q + {3'b000, sync2_q};
            evals_d = evals_q + 4'd1;
            state_d = ((evals_q + 4'd1) < EV_ALL) ? S_SETUP : S_VOTE;
         end
         S_VOTE: begin
            word_d  = {word_q[6:0], vote_bit};
            mask_d  = {mask_q[6:0], vote_unstable};
            votes_d = 4'd0;
            evals_d = 4'd0;
            chal_d  = chal_next;
            bit_d   = bit_q + 3'd1;
            state_d = (bit_q == 3'd7) ? S_OUT : S_SETUP;
         end
         S_OUT: begin
            // word_valid appears one cycle after entering OUT and drops with the handshake.
            valid_d = !(valid_q && word_ready);
            if (valid_q && word_ready) begin
               words_d = words_q - 8'd1;
               state_d = (words_q == 8'd1) ? S_FINISH : S_SETUP;
            end
         end
         S_FINISH: begin
            busy_d  = 1'b0;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign challenge  = chal_q;
   assign pulse      = pulse_q;
   assign word_valid = valid_q;
   assign word       = word_q;
   assign mask       = mask_q;
   assign busy       = busy_q;
   assign done       = done_q;
endmodule

// File: tb/tb_puf_crp_sequencer.sv
// tb/tb_puf_crp_sequencer.sv - randomized model-checked bench for puf_crp_sequencer
module tb_puf_crp_sequencer;
   localparam int EVALS  = 5;
   localparam int SETTLE = 4;
   localparam int T_WORD = 369;

   logic       clk = 1'b0, rst_n = 1'b0, start = 1'b0, response = 1'b0, word_ready = 1'b1;
   logic [7:0] seed = 8'h00, n_words = 8'h00;
   logic [7:0] challenge, word, mask;
   logic       pulse, word_valid, busy, done;

   puf_crp_sequencer #(.EVALS(EVALS), .SETTLE(SETTLE)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .seed(seed), .n_words(n_words),
      .challenge(challenge), .pulse(pulse), .response(response),
      .word_valid(word_valid), .word_ready(word_ready), .word(word), .mask(mask),
      .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   int vectors = 0, miscompares = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference model: response source, challenge sequence, expected words.
   int         mode;
   logic [4:0] rtab [256];
   logic [7:0] exp_chal[$];
   logic [7:0] exp_word[$];
   logic [7:0] exp_mask[$];
   int         n_exp;

   function automatic logic resp_fn(input logic [7:0] c, input int e);
      case (mode)
         0:       return c[0];
         1:       return (e % 2) == 0;
         default: return rtab[c][3'(e)];
      endcase
   endfunction

   function automatic logic [7:0] next_chal(input logic [7:0] c);
`ifdef PUF_CRP_LFSR_EN
      return {c[6:0], c[7] ^ c[5] ^ c[4] ^ c[3]};
`else
      return c + 8'd1;
`endif
   endfunction

   task automatic build_model(input logic [7:0] s, input int n);
      logic [7:0] c, w, m;
      int v;
      c = s;
`ifdef PUF_CRP_LFSR_EN
      if (c == 8'h00) c = 8'h01;
`endif
      exp_chal.delete(); exp_word.delete(); exp_mask.delete();
      for (int k = 0; k < n; k++) begin
         w = 8'h00; m = 8'h00;
         for (int b = 0; b < 8; b++) begin
            v = 0;
            for (int e = 0; e < EVALS; e++) v += int'(resp_fn(c, e));
            w[3'(7 - b)] = (2 * v > EVALS);
            m[3'(7 - b)] = (v != 0) && (v != EVALS);
            exp_chal.push_back(c);
            c = next_chal(c);
         end
         exp_word.push_back(w);
         exp_mask.push_back(m);
      end
      n_exp = n;
   endtask

   // Monitor state
   bit         mon_en = 1'b0, run_active = 1'b0, run_done = 1'b0, done_due = 1'b0;
   bit         prev_pulse = 1'b0, prev_valid = 1'b0;
   int         cyc = 0, ref_cyc = 0, widx = 0, pulse_cnt = 0, bi;
   logic [7:0] chal_hold;
   logic [7:0] got_word [8];
   logic [7:0] got_mask [8];
   logic [7:0] dut_chal [64];
   int         stall_left = 0;
   bit         rand_ready = 1'b0;

   // Ready policy, changed just after each active edge.
   always @(posedge clk) begin
      #2;
      if (word_valid && stall_left > 0) begin
         word_ready = 1'b0;
         stall_left--;
      end else begin
         word_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      end
   end

   // Compare process: checks every cycle on the falling edge.
   always @(negedge clk) begin
      if (mon_en) begin
         chk("done", 32'(done), 32'(done_due));
         done_due = 1'b0;
         chk("busy", 32'(busy), 32'(run_active));
         if (run_active) begin
            if (pulse && !prev_pulse) begin
               bi = pulse_cnt / EVALS;
               if (bi < exp_chal.size()) begin
                  chk("challenge", 32'(challenge), 32'(exp_chal[bi]));
                  if (pulse_cnt % EVALS == 0 && bi < 64) dut_chal[6'(bi)] = challenge;
                  response = resp_fn(exp_chal[bi], pulse_cnt % EVALS);
               end else begin
                  chk("extra_pulse", 32'(pulse), 32'(0));
               end
               pulse_cnt++;
            end
            if (word_valid) begin
               chk("valid_in_range", 32'(widx < n_exp), 32'(1));
               if (widx < n_exp) begin
                  if (!prev_valid) begin
                     chk("valid_time", 32'(cyc - ref_cyc), 32'(T_WORD));
                     chal_hold = challenge;
                  end
                  chk("word", 32'(word), 32'(exp_word[widx]));
                  chk("mask", 32'(mask), 32'(exp_mask[widx]));
                  chk("out_pulse", 32'(pulse), 32'(0));
                  chk("out_challenge", 32'(challenge), 32'(chal_hold));
                  if (word_ready) begin
                     got_word[3'(widx)] = word;
                     got_mask[3'(widx)] = mask;
                     widx++;
                     ref_cyc = cyc + 1;
                     if (widx == n_exp) done_due = 1'b1;
                  end
               end
            end
         end else begin
            chk("idle_valid", 32'(word_valid), 32'(0));
            chk("idle_pulse", 32'(pulse), 32'(0));
         end
         if (done) begin
            run_active = 1'b0;
            run_done   = 1'b1;
         end
         prev_pulse = pulse;
         prev_valid = word_valid;
         cyc++;
      end
   end

   task automatic do_start(input logic [7:0] s, input int n);
      build_model(s, n);
      widx = 0; pulse_cnt = 0; prev_pulse = 1'b0; prev_valid = 1'b0; run_done = 1'b0;
      @(posedge clk); #2;
      start = 1'b1; seed = s; n_words = 8'(n);
      @(posedge clk); #2;
      start = 1'b0; cyc = 0; ref_cyc = 0; run_active = 1'b1; done_due = (n == 0);
   endtask

   task automatic wait_done();
      for (int i = 0; i < 6000 && !run_done; i++) @(posedge clk);
      chk("run_complete", 32'(run_done), 32'(1));
      @(posedge clk);
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_challenge"}, 32'(challenge), 32'(0));
      chk({tag, "_pulse"}, 32'(pulse), 32'(0));
      chk({tag, "_valid"}, 32'(word_valid), 32'(0));
      chk({tag, "_word"}, 32'(word), 32'(0));
      chk({tag, "_mask"}, 32'(mask), 32'(0));
      chk({tag, "_busy"}, 32'(busy), 32'(0));
      chk({tag, "_done"}, 32'(done), 32'(0));
   endtask

   initial begin
      logic [7:0] lf_exp [5];
      int r;
      for (int c = 0; c < 256; c++) begin
         r = $urandom_range(0, 3);
         rtab[c] = (r == 0) ? 5'($urandom) : ((r == 1) ? 5'h1F : 5'h00);
      end
      repeat (3) @(posedge clk);
      #1 chk_reset_vals("reset");
      @(negedge clk);
      rst_n  = 1'b1;
      mon_en = 1'b1;

      // Counter mode, response = challenge[0]
      mode = 0;
      do_start(8'h10, 1);
      wait_done();
      chk("t1_word", 32'(got_word[0]), 32'h55);
      chk("t1_mask", 32'(got_mask[0]), 32'h00);
`ifndef PUF_CRP_LFSR_EN
      for (int b = 0; b < 8; b++) chk("t1_chal", 32'(dut_chal[b]), 32'(8'h10 + 8'(b)));
`endif

      // Toggling response: 1,0,1,0,1 per challenge
      mode = 1;
      do_start(8'($urandom), 1);
      wait_done();
      chk("t2_word", 32'(got_word[0]), 32'hFF);
      chk("t2_mask", 32'(got_mask[0]), 32'hFF);

      // Consumer stall for 20 cycles; a stray start mid-run must be ignored
      mode = 0;
      stall_left = 20;
      do_start(8'h10, 2);
      repeat (50) @(posedge clk);
      #2 start = 1'b1; seed = 8'hAA; n_words = 8'd7;
      @(posedge clk);
      #2 start = 1'b0;
      wait_done();
`ifndef PUF_CRP_LFSR_EN
      chk("t3_chal_word2", 32'(dut_chal[8]), 32'h18);
`endif

      // Zero seed: LFSR replaces it with 01h, counter mode starts at 00h
`ifdef PUF_CRP_LFSR_EN
      lf_exp = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h11};
`else
      lf_exp = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h04};
`endif
      do_start(8'h00, 1);
      wait_done();
      for (int b = 0; b < 5; b++) chk("t4_seq", 32'(dut_chal[b]), 32'(lf_exp[b]));

      // n_words = 0
      do_start(8'h5A, 0);
      wait_done();
      chk("t5_challenge", 32'(challenge), 32'h5A);

      // Reset in the middle of word 2's first FIRE phase
      mode = 2;
      do_start(8'($urandom), 3);
      for (int i = 0; i < 2000 && pulse_cnt <= 8 * EVALS; i++) @(negedge clk);
      chk("t6_reached_word2", 32'(pulse_cnt > 8 * EVALS), 32'(1));
      @(negedge clk);
      #1 mon_en = 1'b0; run_active = 1'b0;
      chk("t6_in_fire", 32'(pulse), 32'(1));
      rst_n = 1'b0;
      #1 chk_reset_vals("t6_async");
      repeat (3) begin
         @(negedge clk);
         chk("t6_done_in_reset", 32'(done), 32'(0));
      end
      response = 1'b0;
      rst_n    = 1'b1;
      mon_en   = 1'b1;
      do_start(8'($urandom), 2);
      wait_done();

      // Randomized runs with random backpressure
      rand_ready = 1'b1;
      for (int k = 0; k < 3; k++) begin
         do_start(8'($urandom), $urandom_range(1, 3));
         wait_done();
      end
      rand_ready = 1'b0;

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule

// File: doc/puf_crp_sequencer.md
# puf_crp_sequencer

Challenge-response collection engine that drives the arbiter PUF from the initiator side. It issues 8-bit challenges and generates the launch pulse for each evaluation. It samples the single-bit response, majority-votes it over repeated evaluations, and packs the voted bits into 8-bit words, each with a per-bit instability mask. It sits between the PUF macro (challenge/pulse out, response in) and the host-side readout logic (valid/ready word stream).

## Interface
- EVALS, 5: evaluations per challenge; odd, 1..15.
- SETTLE, 4: cycles per pulse phase (low and high); minimum 3.

- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  begin a run; sampled only in IDLE
- seed  input  8  first challenge of the run, latched on start
- n_words  input  8  words to produce, latched on start; 0 = none
- challenge  output  8  challenge driven to the PUF
- pulse  output  1  launch pulse to the PUF delay line
- response  input  1  raw PUF arbiter output, asynchronous to clk
- word_valid  output  1  word/mask available
- word_ready  input  1  consumer accepts word
- word  output  8  voted responses; first challenge of the word lands in bit 7
- mask  output  8  bit set = that challenge's votes were not unanimous
- busy  output  1  run in progress
- done  output  1  one-cycle pulse at end of run

## Operation
- States: IDLE, SETUP, FIRE, SAMPLE, VOTE, OUT, FINISH.
- IDLE
  - On start: latch seed into challenge and n_words into the word counter.
  - Clear the vote, eval, bit and mask accumulators. Set busy.
  - Go to FINISH if n_words==0, else to SETUP.
- Synchronizer: response passes through a 2-flop synchronizer. Only the synchronized value is used.
- SETUP: pulse=0 for SETTLE cycles, then FIRE.
- FIRE: pulse=1 for SETTLE cycles, then SAMPLE.
- SAMPLE (1 cycle)
  - pulse=0. Add the synchronized response to the 4-bit vote count and increment the eval count.
  - Go to SETUP if eval count < EVALS, else VOTE.
- VOTE (1 cycle)
  - Compute bit = (votes > EVALS/2) and unstable = (votes != 0 && votes != EVALS).
  - Shift both into the word/mask shift registers at bit 0, shifting left.
  - Clear votes and eval count, and advance challenge.
  - Go to OUT after the 8th bit of a word, else SETUP.
- OUT
  - word_valid=1, with word and mask held stable.
  - On word_valid&&word_ready: decrement the word counter, then go to FINISH if it reaches 0, else SETUP.
  - Challenge sequence continues across words.
- FINISH (1 cycle): done=1, busy=0 next cycle, return to IDLE.
- Challenge advance, counter mode: challenge+1, wrapping 8'hFF to 8'h00.
- start asserted while busy is ignored.
- Reset at any point forces IDLE and reset values. The run is abandoned and no done pulse is issued.

## Timing
- Reset values: challenge=0, pulse=0, word_valid=0, word=0, mask=0, busy=0, done=0.
- busy rises the cycle after start is sampled.
- One evaluation takes 2*SETTLE+1 cycles. One bit takes EVALS*(2*SETTLE+1)+1 cycles.
- word_valid rises 8*(EVALS*(2*SETTLE+1)+1)+1 cycles after the start edge for the first word. With defaults this is 369.
- The next word's SETUP starts the cycle after the handshake. There is no bubble beyond OUT's handshake cycle.
- challenge is stable from SETUP entry through SAMPLE for every evaluation.
- done fires the cycle after the final handshake, or 1 cycle after start when n_words==0.

## Configuration
- PUF_CRP_LFSR_EN
  - Defined: challenge advances as an 8-bit Fibonacci LFSR, x^8+x^6+x^5+x^4+1. The next value is {c[6:0], c[7]^c[5]^c[4]^c[3]}.
  - Defined, seed 0: seed is replaced by 8'h01 on latch.
  - Undefined: counter mode, and seed is used as-is.

## Test plan
- Counter mode, defaults, seed=8'h10, n_words=1, response model = challenge[0]
  - Challenges 10h..17h in order.
  - word=8'h55, mask=8'h00, word_valid at cycle 369, done one cycle after handshake.
- Response toggling every evaluation (1,0,1,0,1 per challenge), n_words=1
  - word=8'hFF, mask=8'hFF.
- word_ready held low 20 cycles after word_valid
  - word/mask/challenge stable, pulse stays 0, engine stalls.
  - Second word starts with challenge 18h after accept.
- PUF_CRP_LFSR_EN defined, seed=0: challenge sequence 01h, 02h, 04h, 08h, 11h.
- n_words=0: done pulses 1 cycle after start, word_valid never asserts, challenge=seed.
- rst_n low mid-FIRE of word 2: all outputs return to reset values immediately. A new start then runs cleanly from its seed.
